// File: rtl/lot_occupancy_tracker.sv
// Parking-lot occupancy tracker: saturating car count, full/empty/error flags,
// wrapping daily-entries total and a multi-cycle double-dabble BCD converter.
module lot_occupancy_tracker #(
  parameter int unsigned CAPACITY = 25,
  parameter int unsigned CW       = 5,
  parameter int unsigned TW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enter,
  input  logic          exit,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          overflow_err,
  output logic          underflow_err,
  output logic [TW-1:0] total_entries,
  output logic [3:0]    bcd_tens,
  output logic [3:0]    bcd_ones,
  output logic          bcd_valid,
  output logic [1:0]    disp_mode
);

  localparam int unsigned DW  = 8 + CW;
  localparam int unsigned SCW = $clog2(CW + 1);
  localparam logic [CW-1:0]  CAP       = CW'(CAPACITY);
  localparam logic [SCW-1:0] LAST_STEP = SCW'(CW - 1);

  localparam logic [1:0] DISP_CLEAR  = 2'd0;
  localparam logic [1:0] DISP_NUMBER = 2'd1;
  localparam logic [1:0] DISP_FULL   = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } bcd_state_e;

  // Event decode: classify this cycle's enter/exit against the current count
  logic          do_inc;
  logic          do_dec;
  logic          tot_inc;
  logic          ovf_evt;
  logic          unf_evt;
  logic          change;
  logic [CW-1:0] count_next;

  always_comb begin
    do_inc     = 1'b0;
    do_dec     = 1'b0;
    tot_inc    = 1'b0;
    ovf_evt    = 1'b0;
    unf_evt    = 1'b0;
    count_next = count;
    unique case ({enter, exit})
      2'b10: begin
        if (count != CAP) begin
          do_inc  = 1'b1;
          tot_inc = 1'b1;
        end else begin
          ovf_evt = 1'b1;
        end
      end
      2'b01: begin
        if (count != '0) do_dec = 1'b1;
        else             unf_evt = 1'b1;
      end
      2'b11: tot_inc = (count != CAP);
      default: ;
    endcase
    if (do_inc) count_next = count + CW'(1);
    if (do_dec) count_next = count - CW'(1);
  end

  assign change = do_inc | do_dec;

  // Occupancy, flags and entry total
  always_ff @(posedge clk) begin
    if (reset) begin
      count         <= '0;
      total_entries <= '0;
      full          <= 1'b0;
      empty         <= 1'b1;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
      disp_mode     <= DISP_CLEAR;
    end else begin
      count         <= count_next;
      if (tot_inc) total_entries <= total_entries + TW'(1);
      full          <= (count_next == CAP);
      empty         <= (count_next == '0);
      overflow_err  <= ovf_evt;
      underflow_err <= unf_evt;
      if (count_next == '0)       disp_mode <= DISP_CLEAR;
      else if (count_next == CAP) disp_mode <= DISP_FULL;
      else                        disp_mode <= DISP_NUMBER;
    end
  end

  // One double-dabble step: add 3 to any BCD nibble >= 5, then shift left
  function automatic logic [DW-1:0] dd_step(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    r = v;
    if (r[DW-1 -: 4] >= 4'd5) r[DW-1 -: 4] = r[DW-1 -: 4] + 4'd3;
    if (r[DW-5 -: 4] >= 4'd5) r[DW-5 -: 4] = r[DW-5 -: 4] + 4'd3;
    return r << 1;
  endfunction

  bcd_state_e     state;
  bcd_state_e     state_next;
  logic [DW-1:0]  dd;
  logic [DW-1:0]  dd_next;
  logic [SCW-1:0] step;
  logic [SCW-1:0] step_next;
  logic [3:0]     tens_next;
  logic [3:0]     ones_next;
  logic           valid_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      dd        <= '0;
      step      <= '0;
      bcd_tens  <= 4'd0;
      bcd_ones  <= 4'd0;
      bcd_valid <= 1'b1;
    end else begin
      state     <= state_next;
      dd        <= dd_next;
      step      <= step_next;
      bcd_tens  <= tens_next;
      bcd_ones  <= ones_next;
      bcd_valid <= valid_next;
    end
  end

  // Any accepted change (re)starts conversion from the newest count
  always_comb begin
    state_next = state;
    dd_next    = dd;
    step_next  = step;
    tens_next  = bcd_tens;
    ones_next  = bcd_ones;
    valid_next = bcd_valid;
    if (change) begin
      state_next = SHIFT;
      dd_next    = {8'd0, count_next};
      step_next  = '0;
      valid_next = 1'b0;
    end else begin
      unique case (state)
        SHIFT: begin
          dd_next   = dd_step(dd);
          step_next = step + SCW'(1);
          if (step == LAST_STEP) state_next = LOAD;
        end
        LOAD: begin
          tens_next  = dd[DW-1 -: 4];
          ones_next  = dd[DW-5 -: 4];
          valid_next = 1'b1;
          state_next = IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lot_occupancy_tracker.sv
// Directed bench for lot_occupancy_tracker with a cycle-level reference model
// built from occupancy rules and conversion latency, checked every cycle.
module tb_lot_occupancy_tracker;

  localparam int CAPACITY = 25;
  localparam int CW       = 5;
  localparam int TW       = 8;

  logic          clk;
  logic          reset;
  logic          enter;
  logic          exit;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          overflow_err;
  logic          underflow_err;
  logic [TW-1:0] total_entries;
  logic [3:0]    bcd_tens;
  logic [3:0]    bcd_ones;
  logic          bcd_valid;
  logic [1:0]    disp_mode;

  lot_occupancy_tracker #(.CAPACITY(CAPACITY), .CW(CW), .TW(TW)) dut (
    .clk(clk), .reset(reset), .enter(enter), .exit(exit),
    .count(count), .full(full), .empty(empty),
    .overflow_err(overflow_err), .underflow_err(underflow_err),
    .total_entries(total_entries), .bcd_tens(bcd_tens), .bcd_ones(bcd_ones),
    .bcd_valid(bcd_valid), .disp_mode(disp_mode)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: occupancy rules plus "digits land CW+1 edges after the last change"
  int m_cnt, m_tot, m_tens, m_ones, since;
  bit m_ovf, m_unf, m_valid, started = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_cnt = 0; m_tot = 0; m_ovf = 0; m_unf = 0;
      m_tens = 0; m_ones = 0; m_valid = 1; since = 1000; started = 1;
    end else if (started) begin
      bit chg;
      chg = 0; m_ovf = 0; m_unf = 0;
      if (enter && !exit) begin
        if (m_cnt < CAPACITY) begin m_cnt++; m_tot = (m_tot + 1) % (1 << TW); chg = 1; end
        else m_ovf = 1;
      end else if (exit && !enter) begin
        if (m_cnt > 0) begin m_cnt--; chg = 1; end
        else m_unf = 1;
      end else if (enter && exit && m_cnt < CAPACITY) begin
        m_tot = (m_tot + 1) % (1 << TW);
      end
      if (chg) begin
        since = 0; m_valid = 0;
      end else if (since < 1000) begin
        since++;
        if (since == CW + 1) begin m_tens = m_cnt / 10; m_ones = m_cnt % 10; m_valid = 1; end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("count",         32'(count),         32'(m_cnt));
      check("full",          32'(full),          32'(m_cnt == CAPACITY));
      check("empty",         32'(empty),         32'(m_cnt == 0));
      check("overflow_err",  32'(overflow_err),  32'(m_ovf));
      check("underflow_err", 32'(underflow_err), 32'(m_unf));
      check("total_entries", 32'(total_entries), 32'(m_tot));
      check("disp_mode",     32'(disp_mode),     32'(m_cnt == 0 ? 0 : (m_cnt == CAPACITY ? 2 : 1)));
      check("bcd_valid",     32'(bcd_valid),     32'(m_valid));
      check("bcd_tens",      32'(bcd_tens),      32'(m_tens));
      check("bcd_ones",      32'(bcd_ones),      32'(m_ones));
    end
  end

  task automatic pulse(input logic e, input logic x);
    @(negedge clk); enter = e; exit = x;
    @(negedge clk); enter = 1'b0; exit = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; enter = 1'b0; exit = 1'b0;
    idle(2);
    reset = 1'b0;
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_bcd_valid", 32'(bcd_valid), 1);

    // 1: three entries, digits settle CW+1 edges later
    repeat (3) pulse(1'b1, 1'b0);
    check("t1_count", 32'(count), 3);
    check("t1_total", 32'(total_entries), 3);
    check("t1_disp", 32'(disp_mode), 1);
    check("t1_valid_low", 32'(bcd_valid), 0);
    idle(CW + 1);
    check("t1_valid", 32'(bcd_valid), 1);
    check("t1_ones", 32'(bcd_ones), 3);

    // 2: fill and overflow
    repeat (22) pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    check("t2_ovf", 32'(overflow_err), 1);
    check("t2_count", 32'(count), 25);
    check("t2_full", 32'(full), 1);
    check("t2_disp", 32'(disp_mode), 2);
    check("t2_total", 32'(total_entries), 25);
    idle(1);
    check("t2_ovf_clear", 32'(overflow_err), 0);
    idle(CW + 1);
    check("t2_tens", 32'(bcd_tens), 2);
    check("t2_ones", 32'(bcd_ones), 5);

    // 3: drain and underflow
    repeat (25) pulse(1'b0, 1'b1);
    idle(CW + 2);
    pulse(1'b0, 1'b1);
    check("t3_unf", 32'(underflow_err), 1);
    check("t3_count", 32'(count), 0);
    check("t3_valid", 32'(bcd_valid), 1);

    // 4: simultaneous enter+exit below and at capacity
    repeat (10) pulse(1'b1, 1'b0);
    idle(CW + 2);
    pulse(1'b1, 1'b1);
    check("t4_count", 32'(count), 10);
    check("t4_total", 32'(total_entries), 36);
    check("t4_valid", 32'(bcd_valid), 1);
    repeat (15) pulse(1'b1, 1'b0);
    idle(CW + 2);
    pulse(1'b1, 1'b1);
    check("t4_full_count", 32'(count), 25);
    check("t4_full_total", 32'(total_entries), 51);
    check("t4_full_ovf", 32'(overflow_err), 0);

    // 5: back-to-back entries, only the final count shows
    repeat (15) pulse(1'b0, 1'b1);
    idle(CW + 2);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    idle(CW);
    check("t5_valid_low", 32'(bcd_valid), 0);
    idle(1);
    check("t5_valid", 32'(bcd_valid), 1);
    check("t5_tens", 32'(bcd_tens), 1);
    check("t5_ones", 32'(bcd_ones), 2);

    // 6: reset mid-conversion, then total wrap
    repeat (5) pulse(1'b1, 1'b0);
    idle(2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_count", 32'(count), 0);
    check("t6_total", 32'(total_entries), 0);
    check("t6_valid", 32'(bcd_valid), 1);
    check("t6_digits", 32'({bcd_tens, bcd_ones}), 0);
    check("t6_disp", 32'(disp_mode), 0);
    repeat (260) pulse(1'b1, 1'b1);
    check("t6_wrap", 32'(total_entries), 4);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
